// File: rtl/redirect_remap_if.sv
// ---------------------------------------------------------------------------
// redirect_remap_if
// Groups the per-target-port signals between the redirect detector / crossbar
// and redirect_remap_ctrl. Each vector carries one lane per target port.
//   redirect_valid_i, source_i, target_i : redirect request from the detector
//   aw_fire_i, b_fire_i                  : AW / B handshakes on each port
//   block_aw_o                           : crossbar must hold AW ready low
//   remap_valid_o, remap_src_o, remap_tgt_o : committed remap table
//   remap_update_o                       : one-cycle pulse on each commit
//   timeout_o, cnt_err_o                 : sticky status flags
// Modports: master = detector/crossbar side, slave = remap controller.
// ---------------------------------------------------------------------------
interface redirect_remap_if #(
   parameter int N_TARG_PORT = 7,
   parameter int LOG_N_INIT  = 2
);
   logic [N_TARG_PORT-1:0]            redirect_valid_i;
   logic [N_TARG_PORT*LOG_N_INIT-1:0] source_i;
   logic [N_TARG_PORT*LOG_N_INIT-1:0] target_i;
   logic [N_TARG_PORT-1:0]            aw_fire_i;
   logic [N_TARG_PORT-1:0]            b_fire_i;
   logic [N_TARG_PORT-1:0]            block_aw_o;
   logic [N_TARG_PORT-1:0]            remap_valid_o;
   logic [N_TARG_PORT*LOG_N_INIT-1:0] remap_src_o;
   logic [N_TARG_PORT*LOG_N_INIT-1:0] remap_tgt_o;
   logic [N_TARG_PORT-1:0]            remap_update_o;
   logic [N_TARG_PORT-1:0]            timeout_o;
   logic [N_TARG_PORT-1:0]            cnt_err_o;

   modport master (
      output redirect_valid_i, source_i, target_i, aw_fire_i, b_fire_i,
      input  block_aw_o, remap_valid_o, remap_src_o, remap_tgt_o,
             remap_update_o, timeout_o, cnt_err_o
   );

   modport slave (
      input  redirect_valid_i, source_i, target_i, aw_fire_i, b_fire_i,
      output block_aw_o, remap_valid_o, remap_src_o, remap_tgt_o,
             remap_update_o, timeout_o, cnt_err_o
   );
endinterface

// File: rtl/redirect_remap_ctrl.sv
// ---------------------------------------------------------------------------
// redirect_remap_ctrl
// Turns the redirect detector's per-port request levels into a safely applied
// crossbar remap table. Per target port: counts outstanding write bursts,
// blocks new AW while a remap change is pending, waits for in-flight writes
// to drain (or a drain timeout), then commits the new remap in one cycle.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : redirect_remap_if slave modport (requests, handshakes, remap out)
// ---------------------------------------------------------------------------
module redirect_remap_ctrl #(
   parameter int N_TARG_PORT   = 7,
   parameter int LOG_N_INIT    = 2,
   parameter int OUTST_W       = 4,
   parameter int DRAIN_TIMEOUT = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   redirect_remap_if.slave        bus
);
   localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]   TMR_ZERO = {TMR_W{1'b0}};
   localparam logic [OUTST_W-1:0] CNT_MAX  = {OUTST_W{1'b1}};
   localparam logic [OUTST_W-1:0] CNT_ZERO = {OUTST_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_port
      state_t                  state_r, state_nxt_s;
      logic [OUTST_W-1:0]      cnt_r, cnt_nxt_s;
      logic [TMR_W-1:0]        tmr_r, tmr_nxt_s;
      logic                    cnt_err_r, cnt_err_nxt_s;
      logic                    timeout_r, timeout_nxt_s;
      logic                    remap_valid_r;
      logic [LOG_N_INIT-1:0]   remap_src_r, remap_tgt_r;
      logic                    mismatch_s;
      logic                    req_valid_s, aw_s, b_s;
      logic [LOG_N_INIT-1:0]   req_src_s, req_tgt_s;

      assign req_valid_s = bus.redirect_valid_i[p];
      assign req_src_s   = bus.source_i[p*LOG_N_INIT +: LOG_N_INIT];
      assign req_tgt_s   = bus.target_i[p*LOG_N_INIT +: LOG_N_INIT];
      assign aw_s        = bus.aw_fire_i[p];
      assign b_s         = bus.b_fire_i[p];

      // Live request differs from the committed remap (level comparison only).
      assign mismatch_s = (req_valid_s != remap_valid_r) ||
                          (req_valid_s && remap_valid_r &&
                           ({req_src_s, req_tgt_s} != {remap_src_r, remap_tgt_r}));

      // Outstanding-write counter; errors saturate/floor instead of wrapping.
      always_comb begin
         cnt_nxt_s     = cnt_r;
         cnt_err_nxt_s = cnt_err_r;
         if (aw_s && !b_s) begin
            if (cnt_r == CNT_MAX) begin
               cnt_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + 1'b1;
            end
         end else if (b_s && !aw_s) begin
            if (cnt_r == CNT_ZERO) begin
               cnt_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r - 1'b1;
            end
         end else begin
            cnt_nxt_s = cnt_r;
         end
      end

      // Next-state logic: withdrawal wins over commit, drained wins over timeout.
      always_comb begin
         state_nxt_s   = state_r;
         tmr_nxt_s     = tmr_r;
         timeout_nxt_s = timeout_r;
         case (state_r)
            ST_IDLE: begin
               if (mismatch_s) begin
                  state_nxt_s = ST_DRAIN;
                  tmr_nxt_s   = TMR_ZERO;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               tmr_nxt_s = tmr_r + 1'b1;
               if (!mismatch_s) begin
                  state_nxt_s = ST_IDLE;
               end else if (cnt_r == CNT_ZERO) begin
                  state_nxt_s = ST_APPLY;
               end else if (tmr_r == TMR_LAST) begin
                  state_nxt_s   = ST_APPLY;
                  timeout_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end
            ST_APPLY: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end

      // State, counter, timer and sticky flag registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            tmr_r     <= TMR_ZERO;
            cnt_err_r <= 1'b0;
            timeout_r <= 1'b0;
         end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            tmr_r     <= tmr_nxt_s;
            cnt_err_r <= cnt_err_nxt_s;
            timeout_r <= timeout_nxt_s;
         end
      end

      // Committed remap: sampled from the live request at the end of APPLY.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            remap_valid_r <= 1'b0;
            remap_src_r   <= {LOG_N_INIT{1'b0}};
            remap_tgt_r   <= {LOG_N_INIT{1'b0}};
         end else if (state_r == ST_APPLY) begin
            remap_valid_r <= req_valid_s;
            remap_src_r   <= req_src_s;
            remap_tgt_r   <= req_tgt_s;
         end else begin
            remap_valid_r <= remap_valid_r;
            remap_src_r   <= remap_src_r;
            remap_tgt_r   <= remap_tgt_r;
         end
      end

      assign bus.block_aw_o[p]     = (state_r == ST_DRAIN) || (state_r == ST_APPLY);
      assign bus.remap_update_o[p] = (state_r == ST_APPLY);
      assign bus.remap_valid_o[p]  = remap_valid_r;
      assign bus.remap_src_o[p*LOG_N_INIT +: LOG_N_INIT] = remap_src_r;
      assign bus.remap_tgt_o[p*LOG_N_INIT +: LOG_N_INIT] = remap_tgt_r;
      assign bus.timeout_o[p]      = timeout_r;
      assign bus.cnt_err_o[p]      = cnt_err_r;
   end
endmodule

// File: tb/tb_redirect_remap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_redirect_remap_ctrl
// Scoreboard bench: the driver applies directed and random stimulus, advances
// an integer-based reference model once per clock edge and queues the
// expected outputs; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_redirect_remap_ctrl;
   localparam int NP   = 7;
   localparam int LI   = 2;
   localparam int OW   = 4;
   localparam int DTO  = 256;
   localparam int OMAX = (1 << OW) - 1;

   typedef struct packed {
      logic [NP-1:0]    block;
      logic [NP-1:0]    rv;
      logic [NP*LI-1:0] src;
      logic [NP*LI-1:0] tgt;
      logic [NP-1:0]    upd;
      logic [NP-1:0]    to;
      logic [NP-1:0]    err;
   } exp_t;

   logic clk;
   logic rst_n;
   redirect_remap_if #(.N_TARG_PORT(NP), .LOG_N_INIT(LI)) bus();

   redirect_remap_ctrl #(
      .N_TARG_PORT(NP), .LOG_N_INIT(LI), .OUTST_W(OW), .DRAIN_TIMEOUT(DTO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   exp_t exp_q[$];

   // Reference model: outstanding writes as plain ints, drain age (-1 = not
   // draining), a one-cycle commit flag and the committed table.
   int          m_out   [NP];
   int          m_drain [NP];
   bit          m_apply [NP];
   bit          m_rv    [NP];
   logic [1:0]  m_src   [NP];
   logic [1:0]  m_tgt   [NP];
   bit          m_to    [NP];
   bit          m_err   [NP];

   function automatic void chk(string name, logic [NP*LI-1:0] act, logic [NP*LI-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
   endfunction

   // One clock edge of the reference model using the inputs the DUT sampled.
   function automatic void model_step();
      for (int p = 0; p < NP; p++) begin
         bit         rv, aw, b, mis;
         logic [1:0] s, t;
         int         old;
         if (!rst_n) begin
            m_out[p] = 0; m_drain[p] = -1; m_apply[p] = 1'b0; m_rv[p] = 1'b0;
            m_src[p] = 2'd0; m_tgt[p] = 2'd0; m_to[p] = 1'b0; m_err[p] = 1'b0;
         end else begin
            rv  = bus.redirect_valid_i[p];
            s   = bus.source_i[p*LI +: LI];
            t   = bus.target_i[p*LI +: LI];
            aw  = bus.aw_fire_i[p];
            b   = bus.b_fire_i[p];
            mis = (rv != m_rv[p]) || (rv && m_rv[p] && (s != m_src[p] || t != m_tgt[p]));
            old = m_out[p];
            if (aw && !b) begin
               if (old == OMAX) m_err[p] = 1'b1;
               else             m_out[p] = old + 1;
            end else if (b && !aw) begin
               if (old == 0) m_err[p] = 1'b1;
               else          m_out[p] = old - 1;
            end
            if (m_apply[p]) begin
               m_rv[p] = rv; m_src[p] = s; m_tgt[p] = t; m_apply[p] = 1'b0;
            end else if (m_drain[p] < 0) begin
               if (mis) m_drain[p] = 0;
            end else if (!mis) begin
               m_drain[p] = -1;
            end else if (old == 0) begin
               m_drain[p] = -1; m_apply[p] = 1'b1;
            end else if (m_drain[p] == DTO - 1) begin
               m_drain[p] = -1; m_apply[p] = 1'b1; m_to[p] = 1'b1;
            end else begin
               m_drain[p] = m_drain[p] + 1;
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      for (int p = 0; p < NP; p++) begin
         e.block[p]         = (m_drain[p] >= 0) || m_apply[p];
         e.rv[p]            = m_rv[p];
         e.src[p*LI +: LI]  = m_src[p];
         e.tgt[p*LI +: LI]  = m_tgt[p];
         e.upd[p]           = m_apply[p];
         e.to[p]            = m_to[p];
         e.err[p]           = m_err[p];
      end
      return e;
   endfunction

   // Monitor: compare DUT outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [NP*LI-1:0] msk;
         e = exp_q.pop_front();
         for (int p = 0; p < NP; p++) msk[p*LI +: LI] = {LI{e.rv[p]}};
         chk("block_aw",     14'(bus.block_aw_o),     14'(e.block));
         chk("remap_valid",  14'(bus.remap_valid_o),  14'(e.rv));
         chk("remap_src",    bus.remap_src_o & msk,   e.src & msk);
         chk("remap_tgt",    bus.remap_tgt_o & msk,   e.tgt & msk);
         chk("remap_update", 14'(bus.remap_update_o), 14'(e.upd));
         chk("timeout",      14'(bus.timeout_o),      14'(e.to));
         chk("cnt_err",      14'(bus.cnt_err_o),      14'(e.err));
      end
   end

   task automatic step_cycle();
      @(posedge clk);
      #1;
      model_step();
      exp_q.push_back(model_out());
      cyc++;
   endtask

   task automatic idle_cycles(int n);
      for (int i = 0; i < n; i++) begin
         step_cycle();
         bus.aw_fire_i = '0;
         bus.b_fire_i  = '0;
      end
   endtask

   task automatic set_req(int p, bit v, logic [1:0] s, logic [1:0] t);
      bus.redirect_valid_i[p]  = v;
      bus.source_i[p*LI +: LI] = s;
      bus.target_i[p*LI +: LI] = t;
   endtask

   task automatic rand_inputs(int aw_pct, int b_pct, int chg_pct);
      for (int p = 0; p < NP; p++) begin
         bus.aw_fire_i[p] = ($urandom_range(99) < aw_pct);
         bus.b_fire_i[p]  = ($urandom_range(99) < b_pct);
         if ($urandom_range(99) < chg_pct)
            set_req(p, ($urandom_range(3) != 0), 2'($urandom_range(3)), 2'($urandom_range(3)));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.redirect_valid_i = '0;
      bus.source_i = '0;
      bus.target_i = '0;
      bus.aw_fire_i = '0;
      bus.b_fire_i = '0;
      idle_cycles(3);
      rst_n = 1'b1;
      idle_cycles(6);

      // Idle port 2 gets a redirect src=1 tgt=3.
      set_req(2, 1'b1, 2'd1, 2'd3);
      idle_cycles(8);

      // Port 0: three outstanding bursts, B responses at +5, +8, +20.
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         bus.aw_fire_i[0] = 1'b1;
      end
      step_cycle();
      bus.aw_fire_i[0] = 1'b0;
      set_req(0, 1'b1, 2'd2, 2'd1);
      for (int i = 1; i <= 30; i++) begin
         step_cycle();
         bus.b_fire_i[0] = (i == 5 || i == 8 || i == 20);
      end
      bus.b_fire_i[0] = 1'b0;

      // Port 1: one burst never answered -> drain timeout.
      step_cycle();
      bus.aw_fire_i[1] = 1'b1;
      step_cycle();
      bus.aw_fire_i[1] = 1'b0;
      set_req(1, 1'b1, 2'd2, 2'd0);
      idle_cycles(DTO + 10);
      chk("timeout_p1_sticky", 14'(bus.timeout_o[1]), 14'd1);

      // Port 5: request raised then withdrawn while draining.
      for (int i = 0; i < 2; i++) begin
         step_cycle();
         bus.aw_fire_i[5] = 1'b1;
      end
      step_cycle();
      bus.aw_fire_i[5] = 1'b0;
      set_req(5, 1'b1, 2'd3, 2'd2);
      idle_cycles(3);
      set_req(5, 1'b0, 2'd3, 2'd2);
      idle_cycles(6);
      chk("withdraw_p5_no_remap", 14'(bus.remap_valid_o[5]), 14'd0);

      // Port 6: simultaneous AW/B with two outstanding, then B underflow.
      for (int i = 0; i < 2; i++) begin
         step_cycle();
         bus.aw_fire_i[6] = 1'b1;
      end
      step_cycle();
      bus.b_fire_i[6] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         bus.aw_fire_i[6] = 1'b0;
      end
      idle_cycles(2);

      // Port 4: reset pulse while draining; request persists afterwards.
      step_cycle();
      bus.aw_fire_i[4] = 1'b1;
      step_cycle();
      bus.aw_fire_i[4] = 1'b0;
      set_req(4, 1'b1, 2'd1, 2'd2);
      idle_cycles(4);
      rst_n = 1'b0;
      step_cycle();
      rst_n = 1'b1;
      idle_cycles(10);

      // Port 3: overflow the outstanding counter.
      for (int i = 0; i < 20; i++) begin
         step_cycle();
         bus.aw_fire_i[3] = 1'b1;
      end
      idle_cycles(2);

      // Random traffic: growing backlog, then draining backlog, rare resets.
      for (int i = 0; i < 1500; i++) begin
         step_cycle();
         rst_n = ($urandom_range(599) != 0);
         rand_inputs(40, 25, 3);
      end
      for (int i = 0; i < 1000; i++) begin
         step_cycle();
         rst_n = ($urandom_range(599) != 0);
         rand_inputs(20, 40, 4);
      end
      rst_n = 1'b1;
      idle_cycles(4);

      @(negedge clk);
      #1;
      chk("scoreboard_empty", 14'(exp_q.size()), 14'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
